// File: rtl/mips32_seq_pkg.sv
// Shared types and constants for the mips32 instruction sequencer.
// The SEQ_TIMEOUT_EN build uses TIMEOUT_MARKER as the result of a timed-out instruction.
package mips32_seq_pkg;

  localparam int unsigned SEQ_DATA_W = 32;
  localparam logic [31:0] TIMEOUT_MARKER = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRes,
    StDone
  } seq_state_e;

endpackage

// File: rtl/mips32_instr_sequencer_if.sv
// Instruction/result handshake between the sequencer (master) and the mips32 core (slave).
interface mips32_instr_sequencer_if #(
  parameter int unsigned DATA_W = mips32_seq_pkg::SEQ_DATA_W
) ();

  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] result_in;
  logic              result_valid;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready,
    input  result_in,
    input  result_valid
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    output result_in,
    output result_valid
  );

endinterface

// File: rtl/mips32_seq_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A same-cycle write and read of one entry returns the old contents.
module mips32_seq_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/mips32_instr_sequencer.sv
// Handshake-driven instruction sequencer: issues a loaded program to the core and captures results.
// Define SEQ_TIMEOUT_EN to add a per-instruction result watchdog and the sticky err output.
module mips32_instr_sequencer
  import mips32_seq_pkg::*;
#(
  parameter int unsigned DATA_W         = SEQ_DATA_W,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [ADDR_W-1:0] res_rd_addr,
  output logic [DATA_W-1:0] res_rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   issued_cnt,
`ifdef SEQ_TIMEOUT_EN
  output logic              err,
`endif
  mips32_instr_sequencer_if.master core
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q;
  logic [ADDR_W-1:0] prog_raddr;
  logic [DATA_W-1:0] prog_rdata;
  logic [DATA_W-1:0] res_wdata;
  logic [ADDR_W:0]   len_clamped;
  logic              start_ok, res_fire, last, timeout;

  assign start_ok    = start && (state_q == StIdle || state_q == StDone);
  assign len_clamped = (prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : prog_len;
  assign last        = ({1'b0, idx_q} + (ADDR_W+1)'(1)) == len_q;
  assign res_fire    = (state_q == StWaitRes) && (core.result_valid || timeout);
  assign res_wdata   = core.result_valid ? core.result_in : DATA_W'(TIMEOUT_MARKER);

  assign busy             = (state_q == StIssue) || (state_q == StWaitRes);
  assign done             = (state_q == StDone);
  assign issued_cnt       = cnt_q;
  assign core.instr_valid = (state_q == StIssue);
  // The RAM read for prog[0] launched at start misses a same-cycle load; forward that word.
  assign core.instr_out   = core.instr_valid ? (byp_q ? byp_data_q : prog_rdata) : '0;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdogW-1:0] wdog_q;
  logic             err_q;

  assign timeout = (state_q == StWaitRes) && !core.result_valid &&
                   (wdog_q == WdogW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != StWaitRes || core.result_valid || timeout) wdog_q <= '0;
      else                                                      wdog_q <= wdog_q + 1'b1;
      if (start_ok)     err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    byp_d      = 1'b0;
    prog_raddr = idx_q;
    case (state_q)
      StIdle, StDone: begin
        prog_raddr = '0;
        if (start_ok) begin
          len_d   = len_clamped;
          idx_d   = '0;
          cnt_d   = '0;
          byp_d   = load_we && (load_addr == '0);
          state_d = (len_clamped == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (core.instr_ready) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (res_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d      = idx_q + 1'b1;
            prog_raddr = idx_q + 1'b1;
            state_d    = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      byp_q   <= byp_d;
      if (byp_d) byp_data_q <= load_data;
    end
  end

  mips32_seq_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_prog_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (load_we && !busy),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(prog_raddr),
    .rdata(prog_rdata)
  );

  mips32_seq_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_res_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (res_fire),
    .waddr(idx_q),
    .wdata(res_wdata),
    .raddr(res_rd_addr),
    .rdata(res_rd_data)
  );

endmodule

// File: tb/tb_mips32_instr_sequencer.sv
// Scoreboard bench for mips32_instr_sequencer with a randomised core model.
// Build with SEQ_TIMEOUT_EN defined to also exercise the result watchdog.
module tb_mips32_instr_sequencer;
  import mips32_seq_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned TO    = 8;

  logic          clk, rst, load_we, start;
  logic [AW-1:0] load_addr, res_rd_addr;
  logic [DW-1:0] load_data, res_rd_data;
  logic [AW:0]   prog_len, issued_cnt;
  logic          busy, done;
`ifdef SEQ_TIMEOUT_EN
  logic          err;
`endif

  mips32_instr_sequencer_if #(.DATA_W(DW)) core_if ();

  mips32_instr_sequencer #(
    .DATA_W        (DW),
    .DEPTH         (DEPTH),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .prog_len   (prog_len),
    .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data),
    .busy       (busy),
    .done       (done),
    .issued_cnt (issued_cnt),
`ifdef SEQ_TIMEOUT_EN
    .err        (err),
`endif
    .core       (core_if.master)
  );

  // Reference state: program image, expected issue order, core-side knobs and counters.
  logic [DW-1:0] prog_model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int  tests = 0, fails = 0;
  bit  ready_rand = 0, delay_rand = 0, stray_en = 0;
  int  stall_idx = -1, stall_len = 0, suppress_idx = -1;
  int  hs_cnt = 0, acc_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core model: samples the handshake at negedge, drives ready/result just after posedge.
  initial begin
    bit            hs, rst_s, pending, real_drv, to_active;
    int            dly, to_cnt, stall_done, cur;
    logic [DW-1:0] instr, held;
    pending = 0; real_drv = 0; to_active = 0; dly = 0; to_cnt = 0; stall_done = 0;
    held = '0;
    core_if.instr_ready  = 1'b1;
    core_if.result_valid = 1'b0;
    core_if.result_in    = '0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      hs    = core_if.instr_valid && core_if.instr_ready && !rst;
      instr = core_if.instr_out;
      @(posedge clk);
      #1;
      if (real_drv && !rst_s) acc_cnt++;
      real_drv = 0;
      core_if.result_valid = 1'b0;
      if (rst_s) begin
        pending = 0; to_active = 0; stall_done = 0;
      end else if (hs) begin
        cur = hs_cnt;
        hs_cnt++;
        stall_done = 0;
        if (cur == suppress_idx) begin
          to_active = 1;
          to_cnt    = TO;
        end else begin
          pending = 1;
          held    = instr;
          dly     = delay_rand ? int'($urandom_range(0, 3)) : 1;
        end
      end
      if (to_active) begin
        to_cnt--;
        if (to_cnt == 0) begin
          to_active = 0;
          acc_cnt++;
        end
      end
      if (pending) begin
        if (dly == 0) begin
          core_if.result_valid = 1'b1;
          core_if.result_in    = held + 1;
          real_drv = 1;
          pending  = 0;
        end else begin
          dly--;
        end
      end else if (stray_en && !to_active && $urandom_range(0, 3) == 0) begin
        core_if.result_valid = 1'b1;
        core_if.result_in    = $urandom;
      end
      if (core_if.instr_valid && hs_cnt == stall_idx && stall_done < stall_len) begin
        core_if.instr_ready = 1'b0;
        stall_done++;
      end else begin
        core_if.instr_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops the expected instruction on every accepted handshake.
  initial begin
    bit            hold_v;
    logic [DW-1:0] hold_d, e;
    hold_v = 0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 32'(core_if.instr_valid), 32'd1);
          check("hold_data", core_if.instr_out, hold_d);
        end
        if (core_if.instr_valid && core_if.instr_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_issue: got %h expected none", core_if.instr_out);
          end else begin
            e = exp_q.pop_front();
            check("issue_data", core_if.instr_out, e);
          end
        end
        if (busy) check("issued_cnt_live", 32'(issued_cnt), 32'(acc_cnt));
        hold_v = core_if.instr_valid && !core_if.instr_ready;
        hold_d = core_if.instr_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(core_if.instr_valid), 32'd0);
    check("rst_instr", core_if.instr_out, 32'd0);
    check("rst_cnt", 32'(issued_cnt), 32'd0);
    check("rst_rdata", res_rd_data, 32'd0);
`ifdef SEQ_TIMEOUT_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic read_res(input int i, output logic [DW-1:0] d);
    tick();
    res_rd_addr = AW'(i);
    @(posedge clk);
    @(negedge clk);
    d = res_rd_data;
  endtask

  task automatic run_prog(input int n, input string tag, input bit ld = 0,
                          input logic [AW-1:0] la = '0, input logic [DW-1:0] lv = '0);
    int            len, k;
    logic [DW-1:0] d, er;
    len = (n > DEPTH) ? DEPTH : n;
    if (ld) prog_model[la] = lv;
    for (int i = 0; i < len; i++) exp_q.push_back(prog_model[i]);
    tick();
    start    = 1'b1;
    prog_len = (AW+1)'(n);
    load_we  = ld;
    load_addr = la;
    load_data = lv;
    hs_cnt   = 0;
    acc_cnt  = 0;
    tick();
    start   = 1'b0;
    load_we = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_cnt"}, 32'(issued_cnt), 32'(len));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    for (int i = 0; i < len; i++) begin
      er = (i == suppress_idx) ? TIMEOUT_MARKER : prog_model[i] + 1;
      read_res(i, d);
      check({tag, "_res"}, d, er);
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; load_we = 1'b0; start = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; res_rd_addr = '0;
    do_reset();

    for (int i = 0; i < DEPTH; i++) begin
      tick();
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = {8'(i + 8'h10), 24'($urandom)};
      prog_model[i] = load_data;
    end
    tick();
    load_we = 1'b0;

    run_prog(10, "basic");

    stall_idx = 2;
    stall_len = 3;
    run_prog(5, "bp");
    stall_idx = -1;

    do_reset();
    tick();
    start    = 1'b1;
    prog_len = '0;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_valid", 32'(core_if.instr_valid), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);

    run_prog(20, "len20");

    // Same-cycle load of prog[0] and start must run with the new word.
    run_prog(3, "ldstart", 1'b1, '0, 32'hC0DE_0000 ^ $urandom);

    ready_rand = 1;
    delay_rand = 1;
    stray_en   = 1;
    fork
      run_prog(12, "ign");
      begin
        repeat (8) tick();
        start     = 1'b1;
        prog_len  = 5'd3;
        load_we   = 1'b1;
        load_addr = 4'd1;
        load_data = 32'hBAD0_0001;
        tick();
        start   = 1'b0;
        load_we = 1'b0;
      end
    join
    run_prog(16, "recheck");

    ready_rand = 0;
    delay_rand = 0;
    stray_en   = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(prog_model[i]);
    tick();
    start    = 1'b1;
    prog_len = 5'd10;
    hs_cnt   = 0;
    acc_cnt  = 0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 500 && hs_cnt < 4; k++) @(negedge clk);
    check("midrst_reach", 32'(hs_cnt >= 4), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_valid", 32'(core_if.instr_valid), 32'd0);
    check("midrst_cnt", 32'(issued_cnt), 32'd0);
    run_prog(10, "rerun");

`ifdef SEQ_TIMEOUT_EN
    suppress_idx = 1;
    run_prog(4, "timeout");
    check("timeout_err", 32'(err), 32'd1);
    suppress_idx = -1;
    run_prog(2, "post_to");
    check("err_cleared", 32'(err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
